// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control sequencer for the CPU datapath.
// It fetches each 2-byte instruction, low byte first, from byte memory
// addressed by PC. It then latches the opcode and hands the instruction to
// the execute unit through a start/done handshake. The block also enforces
// an execute timeout, detects HALT and counts retired instructions.
//
// Optional build macro FETCH_SEQUENCER_SINGLE_STEP_EN: when defined, every
// EXEC exit parks in PAUSE until a step pulse arrives. When undefined, PAUSE
// cannot be reached and step is ignored.
module fetch_sequencer #(
    parameter int              OPC_W    = 4,
    parameter logic [OPC_W-1:0] HALT_OPC = '1,   // all-ones opcode (4'hF)
    parameter int              TMO_CYC  = 16,
    parameter int              CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mem_rdy,
    input  logic             exec_done,
    input  logic [15:0]      ir_in,
    input  logic             step,
    output logic             mem_rd,
    output logic             ir_enable,
    output logic [1:0]       ir_select,
    output logic             ir_lh,
    output logic [3:0]       arf_reg_sel,
    output logic [1:0]       arf_fun_sel,
    output logic [1:0]       arf_o1sel,
    output logic             exec_start,
    output logic [OPC_W-1:0] opcode,
    output logic [2:0]       state_o,
    output logic             exec_timeout,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_FETCH_L = 3'd1,
        S_FETCH_H = 3'd2,
        S_DECODE  = 3'd3,
        S_EXEC    = 3'd4,
        S_HALTED  = 3'd5,
        S_PAUSE   = 3'd6
    } state_t;

    // Shared function encoding of the IR and the ARF.
    localparam logic [1:0] FN_CLR  = 2'b00;
    localparam logic [1:0] FN_LOAD = 2'b01;
    localparam logic [1:0] FN_INC  = 2'b11;

    // ARF enable vector is {PC, AR, SP, PC_prev}.
    localparam logic [3:0] SEL_PC  = 4'b1000;
    localparam logic [1:0] OUTA_PC = 2'b11;

    // The cycle counter only has to reach TMO_CYC-1.
    localparam int              TMO_W    = $clog2(TMO_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    localparam state_t EXEC_EXIT = S_PAUSE;
`else
    localparam state_t EXEC_EXIT = S_FETCH_L;
    // step has no function without single-step support.
    logic step_unused;
    assign step_unused = step;
`endif

    state_t           state;
    logic [TMO_W-1:0] cyc_cnt;
    logic [OPC_W-1:0] ir_opc;

    // Only the opcode field of the IR is relevant to sequencing.
    logic [15-OPC_W:0] ir_low_unused;
    assign ir_opc        = ir_in[15:16-OPC_W];
    assign ir_low_unused = ir_in[15-OPC_W:0];

    // State register plus all registered status (opcode, timeout, count).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_INIT;
            opcode       <= '0;
            exec_timeout <= 1'b0;
            instr_count  <= '0;
            cyc_cnt      <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    state <= S_FETCH_L;
                end
                S_FETCH_L: begin
                    if (mem_rdy) state <= S_FETCH_H;
                end
                S_FETCH_H: begin
                    if (mem_rdy) state <= S_DECODE;
                end
                S_DECODE: begin
                    opcode <= ir_opc;
                    if (ir_opc == HALT_OPC) begin
                        state <= S_HALTED;
                    end else begin
                        state   <= S_EXEC;
                        cyc_cnt <= '0;
                    end
                end
                S_EXEC: begin
                    // done takes priority over a timeout in the same cycle
                    if (exec_done) begin
                        instr_count <= instr_count + CNT_W'(1);
                        state       <= EXEC_EXIT;
                    end else if (cyc_cnt == TMO_LAST) begin
                        exec_timeout <= 1'b1;
                        state        <= EXEC_EXIT;
                    end else begin
                        cyc_cnt <= cyc_cnt + TMO_W'(1);
                    end
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                S_PAUSE: begin
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
                    if (step) state <= S_FETCH_L;
`else
                    state <= S_FETCH_L;
`endif
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    // Control outputs decoded from state; fetch strobes also depend on mem_rdy.
    always_comb begin
        mem_rd      = 1'b0;
        ir_enable   = 1'b0;
        ir_select   = FN_CLR;
        ir_lh       = 1'b0;
        arf_reg_sel = 4'b0000;
        arf_fun_sel = FN_CLR;
        arf_o1sel   = OUTA_PC;
        exec_start  = 1'b0;
        halted      = 1'b0;
        case (state)
            S_INIT: begin
                ir_enable   = 1'b1;
                ir_select   = FN_CLR;
                arf_reg_sel = SEL_PC;
                arf_fun_sel = FN_CLR;
            end
            S_FETCH_L, S_FETCH_H: begin
                mem_rd = 1'b1;
                if (mem_rdy) begin
                    ir_enable   = 1'b1;
                    ir_select   = FN_LOAD;
                    ir_lh       = (state == S_FETCH_H);
                    arf_reg_sel = SEL_PC;
                    arf_fun_sel = FN_INC;
                end
            end
            S_DECODE: begin
                exec_start = (ir_opc != HALT_OPC);
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_o = state;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control sequencer for the CPU datapath: instruction register (IR, 16-bit, byte-loaded via LH), address register file (ARF: PC, AR, SP, PC_prev) and an external execute unit.
- Fetches each 2-byte instruction from byte memory addressed by PC, low byte first, incrementing PC per byte.
- Latches the opcode, hands off to execute via a start/done handshake, enforces an execute timeout and detects HALT.
- Counts retired instructions.

Parameters:
- OPC_W, 4, opcode width, taken from ir_in[15:16-OPC_W].
- HALT_OPC, 4'hF, opcode that enters HALTED instead of EXEC.
- TMO_CYC, 16, max EXEC cycles before timeout, >= 2.
- CNT_W, 16, instr_count width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_rdy  in  1  memory read data valid this cycle.
- exec_done  in  1  execute unit finished the current instruction.
- ir_in  in  16  current IR contents.
- step  in  1  single-step advance pulse; used only with SINGLE_STEP_EN.
- mem_rd  out  1  memory read request, address = ARF outA.
- ir_enable  out  1  IR enable.
- ir_select  out  2  IR function: 00 clear, 01 load, 10 dec, 11 inc.
- ir_lh  out  1  IR byte select: 0 low, 1 high.
- arf_reg_sel  out  4  ARF enables {PC, AR, SP, PC_prev}.
- arf_fun_sel  out  2  ARF function, same encoding as ir_select.
- arf_o1sel  out  2  ARF outA select: 00 AR, 01 SP, 10 PC_prev, 11 PC.
- exec_start  out  1  execute handshake start.
- opcode  out  OPC_W  latched opcode.
- state_o  out  3  current state code.
- exec_timeout  out  1  sticky timeout flag.
- halted  out  1  high in HALTED.
- instr_count  out  CNT_W  retired instruction count.

Behaviour:
- States and codes: INIT=0, FETCH_L=1, FETCH_H=2, DECODE=3, EXEC=4, HALTED=5, PAUSE=6 (PAUSE exists only with SINGLE_STEP_EN).
- Reset (async, any state, including mid-fetch):
  - State becomes INIT.
  - opcode=0, exec_timeout=0, instr_count=0, internal cycle counter=0.
  - Combinational outputs decode from INIT.
- Defaults (all control outputs unless stated): 0; arf_o1sel=11.
- INIT (one cycle):
  - ir_enable=1, ir_select=00 (IR clear).
  - arf_reg_sel=1000, arf_fun_sel=00 (PC clear).
  - Next state: FETCH_L.
- FETCH_L:
  - mem_rd=1; stays while mem_rdy=0.
  - In the cycle mem_rdy=1, Mealy outputs: ir_enable=1, ir_select=01, ir_lh=0, arf_reg_sel=1000, arf_fun_sel=11 (PC+1).
  - Next state: FETCH_H.
- FETCH_H: identical to FETCH_L with ir_lh=1. On mem_rdy=1, next state is DECODE.
- DECODE (one cycle):
  - exec_start=1.
  - opcode <= ir_in[15:16-OPC_W] at the closing edge.
  - If ir_in opcode == HALT_OPC, next state is HALTED and exec_start is suppressed (0). Otherwise next state is EXEC and the cycle counter clears.
- EXEC:
  - exec_done is sampled only in EXEC; exec_done during DECODE is ignored.
  - exec_done=1: instr_count+1 (wraps modulo 2^CNT_W); next state FETCH_L.
  - Otherwise the counter increments. If the counter reaches TMO_CYC-1 without done: exec_timeout <= 1, instr_count unchanged, next state FETCH_L.
  - exec_done and timeout in the same cycle: done wins, no flag.
- HALTED: all control outputs at default, halted=1. Exit only via reset.
- exec_timeout is cleared only by reset.
- Fetch latency with zero-wait memory: INIT→DECODE = 3 cycles; minimum instruction period = 4 cycles (FETCH_L, FETCH_H, DECODE, EXEC with immediate done).
- PC wrap: PC increments 0xFF→0x00 inside the ARF; the sequencer takes no special action.

Optional Feature:
- Macro: FETCH_SEQUENCER_SINGLE_STEP_EN.
- Defined: after every EXEC exit (done or timeout), go to PAUSE instead of FETCH_L. PAUSE holds outputs at default. step=1 moves PAUSE→FETCH_L. step outside PAUSE is ignored.
- Undefined: PAUSE is unreachable, step is unused, and EXEC goes directly to FETCH_L.

Test Plan:
- Reset, then mem_rdy held 1, ir_in=16'h1234, exec_done asserted in the first EXEC cycle -> state_o sequence 0,1,2,3,4,1. PC increment pulses (arf_reg_sel=1000, fun_sel=11) in cycles 2 and 3 with ir_lh 0 then 1. opcode=4'h1; instr_count=1 after EXEC.
- mem_rdy low for 3 cycles in FETCH_L -> mem_rd held 1, no ir_enable or PC increment until mem_rdy rises, then exactly one load and one increment.
- ir_in=16'hF000 at DECODE -> exec_start stays 0, state_o=5, halted=1 persistently. instr_count unchanged; reset returns state_o=0.
- exec_done never asserted -> exec_timeout=1 after 16 EXEC cycles, state returns to FETCH_L, instr_count unchanged. A later done in the same EXEC cycle as a would-be timeout -> no new flag.
- reset pulsed asynchronously mid-FETCH_H -> state_o=0 immediately; opcode, exec_timeout and instr_count are 0; next cycle clears PC/IR.
- With FETCH_SEQUENCER_SINGLE_STEP_EN, after one instruction -> state_o=6 holds for 10 cycles; step pulse -> state_o=1 next cycle.
